// File: rtl/timer_pkg.sv
// Shared constants for the 4-digit BCD timer: active-low segment patterns
// (dp off) and the digit-index width.
package timer_pkg;

  localparam int DIG_IDX_W = 2;

  typedef logic [DIG_IDX_W-1:0] dig_idx_t;
  typedef logic [3:0]           bcd_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment pattern; non-decimal codes
// leave the digit dark.
module seg7_decode
  import timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/timer.sv
// Free-running 4-digit BCD seconds counter driving a multiplexed,
// active-low seven-segment display.
module timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] seven_seg,
  output logic [3:0] digit_en
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [SCN_W-1:0] SCN_MAX = SCN_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] presc_p0;
  logic [SCN_W-1:0] scan_p0;
  dig_idx_t         idx_p0;
  logic [3:0][3:0]  bcd_p0;
  logic [3:0][3:0]  bcd_nxt;
  logic             tick;
  logic             scan_wrap;
  logic             carry;
  bcd_t             cur_digit;
  logic [7:0]       cur_seg;
  logic [7:0]       seg_p1;
  logic [3:0]       en_p1;

  assign tick      = (presc_p0 == PRE_MAX);
  assign scan_wrap = (scan_p0 == SCN_MAX);

  // Decimal ripple increment; 9999 rolls over to 0000 with no extra flag.
  always_comb begin
    carry   = tick;
    bcd_nxt = bcd_p0;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_p0[i] == 4'd9) begin
          bcd_nxt[i] = 4'd0;
        end else begin
          bcd_nxt[i] = bcd_p0[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // ---- stage p0: prescaler, scan counter, digit index, BCD count ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_p0 <= '0;
      scan_p0  <= '0;
      idx_p0   <= '0;
      bcd_p0   <= '0;
    end else begin
      presc_p0 <= tick ? '0 : presc_p0 + PRE_W'(1);
      scan_p0  <= scan_wrap ? '0 : scan_p0 + SCN_W'(1);
      if (scan_wrap) begin
        idx_p0 <= idx_p0 + dig_idx_t'(1);
      end
      bcd_p0 <= bcd_nxt;
    end
  end

  assign cur_digit = bcd_p0[idx_p0];

  seg7_decode u_seg7_decode (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // ---- stage p1: registered display drive, dark while in reset ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_p1 <= SEG_BLANK;
      en_p1  <= 4'hF;
    end else begin
      seg_p1 <= cur_seg;
      en_p1  <= ~(4'b0001 << idx_p0);
    end
  end

  assign seven_seg = seg_p1;
  assign digit_en  = en_p1;

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: hand-computed vector table, reset/scan sequences,
// and an arithmetic reference of the display for every cycle.
module tb_timer;

  typedef struct {
    int         n;
    bit         wide;
    logic [3:0] en;
    logic [7:0] seg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] seg_a, seg_b;
  logic [3:0] en_a,  en_b;

  int  checks = 0;
  int  passed = 0;
  int  n      = 0;
  bit  track  = 1'b0;

  vec_t tbl [23];

  always #5 clk = ~clk;

  timer #(.TICK_DIV(4), .SCAN_DIV(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .seven_seg (seg_a),
    .digit_en  (en_a)
  );

  timer #(.TICK_DIV(8), .SCAN_DIV(2)) u_wide (
    .clk       (clk),
    .rst       (rst),
    .seven_seg (seg_b),
    .digit_en  (en_b)
  );

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Display expected after edge nn (1-based since reset release): the
  // outputs reflect the count and digit index held before that edge.
  function automatic void model(input int nn, input int td, input int sd,
                                output logic [3:0] en, output logic [7:0] sg);
    int m, c, k, d;
    m = nn - 1;
    c = (m / td) % 10000;
    k = (m / sd) % 4;
    d = c;
    for (int j = 0; j < k; j++) d = d / 10;
    d  = d % 10;
    en = ~(4'b0001 << k);
    sg = seg_of(d);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at n=%0d: got %h, want %h", name, n, act, exp);
  endtask

  task automatic step();
    logic [3:0] e;
    logic [7:0] s;
    @(posedge clk);
    #1;
    if (rst) n++;
    if (track && rst) begin
      model(n, 4, 2, e, s);
      check("ref_a_en",  {4'h0, en_a}, {4'h0, e});
      check("ref_a_seg", seg_a, s);
      model(n, 8, 2, e, s);
      check("ref_b_en",  {4'h0, en_b}, {4'h0, e});
      check("ref_b_seg", seg_b, s);
    end
  endtask

  task automatic run_row(input vec_t v);
    while (n < v.n) step();
    if (v.wide) begin
      check($sformatf("tbl_b_en_n%0d", v.n),  {4'h0, en_b}, {4'h0, v.en});
      check($sformatf("tbl_b_seg_n%0d", v.n), seg_b, v.seg);
    end else begin
      check($sformatf("tbl_a_en_n%0d", v.n),  {4'h0, en_a}, {4'h0, v.en});
      check($sformatf("tbl_a_seg_n%0d", v.n), seg_a, v.seg);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not complete (%0d checks so far)", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] scan_seq;

    tbl[0]  = '{1,     1'b0, 4'hE, 8'hC0};
    tbl[1]  = '{3,     1'b0, 4'hD, 8'hC0};
    tbl[2]  = '{5,     1'b0, 4'hB, 8'hC0};
    tbl[3]  = '{7,     1'b0, 4'h7, 8'hC0};
    tbl[4]  = '{9,     1'b0, 4'hE, 8'hA4};
    tbl[5]  = '{9,     1'b1, 4'hE, 8'hF9};
    tbl[6]  = '{10,    1'b1, 4'hE, 8'hF9};
    tbl[7]  = '{11,    1'b0, 4'hD, 8'hC0};
    tbl[8]  = '{37,    1'b0, 4'hB, 8'hC0};
    tbl[9]  = '{41,    1'b0, 4'hE, 8'hC0};
    tbl[10] = '{43,    1'b0, 4'hD, 8'hF9};
    tbl[11] = '{73,    1'b1, 4'hE, 8'h90};
    tbl[12] = '{83,    1'b1, 4'hD, 8'hF9};
    tbl[13] = '{493,   1'b0, 4'hB, 8'hF9};
    tbl[14] = '{495,   1'b0, 4'h7, 8'hC0};
    tbl[15] = '{39993, 1'b0, 4'hE, 8'h80};
    tbl[16] = '{39995, 1'b0, 4'hD, 8'h90};
    tbl[17] = '{39997, 1'b0, 4'hB, 8'h90};
    tbl[18] = '{39999, 1'b0, 4'h7, 8'h90};
    tbl[19] = '{40001, 1'b0, 4'hE, 8'hC0};
    tbl[20] = '{40003, 1'b0, 4'hD, 8'hC0};
    tbl[21] = '{40005, 1'b0, 4'hB, 8'hC0};
    tbl[22] = '{40007, 1'b0, 4'h7, 8'hC0};

    // Held reset: display dark on every edge.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_seg", seg_a, 8'hFF);
      check("rst_hold_en",  {4'h0, en_a}, 8'h0F);
      check("rst_hold_b_en", {4'h0, en_b}, 8'h0F);
    end

    rst   = 1'b1;
    n     = 0;
    track = 1'b1;
    for (int r = 0; r < 15; r++) run_row(tbl[r]);

    // One-cycle reset while the count is 0123.
    rst = 1'b0;
    step();
    check("midrst_seg",   seg_a, 8'hFF);
    check("midrst_en",    {4'h0, en_a}, 8'h0F);
    check("midrst_b_seg", seg_b, 8'hFF);
    rst = 1'b1;
    n   = 0;

    // Eight scan steps after restart, each held two cycles.
    scan_seq = 64'h77BBDDEE77BBDDEE;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("scan_en_%0d", i), {4'h0, en_a}, {4'h0, scan_seq[4*i +: 4]});
      check("scan_onecold", 8'($countones(~en_a)), 8'd1);
      if (i == 0) check("restart_seg", seg_a, 8'hC0);
    end

    for (int r = 15; r < 23; r++) run_row(tbl[r]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
